// File: rtl/mac_iter_sequencer.sv
// mac_iter_sequencer: walks one MAC job iteration by iteration.
// Each iteration gets one streamer request {addr, len, stride} over a valid/ready handshake.
// The sequencer then waits for the engine's per-iteration done pulse before moving on.
// When the job is complete, done_o pulses for one cycle.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no job; waiting for start_i
// ISSUE  | request for iteration idx presented, waiting for req_ready_i
// WAIT   | request accepted, waiting for the engine to finish the iteration
// FINISH | job complete; done_o high for this single cycle

module mac_iter_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  nb_iter_i,
    input  logic [CNT_WIDTH-1:0]  len_iter_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] vect_stride_i,
    input  logic [ADDR_WIDTH-1:0] one_stride_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [CNT_WIDTH-1:0]  req_len_o,
    output logic [ADDR_WIDTH-1:0] req_stride_o,
    input  logic                  eng_done_i,
    output logic [CNT_WIDTH-1:0]  iter_idx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  nb_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] one_stride_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CNT_WIDTH-1:0]  last_idx;

    // nb_q is never zero while in WAIT, so this subtraction never wraps where it is used.
    // Comparing idx against nb-1 instead of incrementing first avoids an idx wrap when
    // nb_iter is at its maximum value.
    assign last_idx = nb_q - CNT_ONE;

    // Sequencer FSM: all outputs are registered. Clear has the same effect as reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            nb_q         <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            stride_q     <= '0;
            one_stride_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            nb_q         <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            stride_q     <= '0;
            one_stride_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        nb_q         <= nb_iter_i;
                        len_q        <= len_iter_i;
                        addr_q       <= base_addr_i;
                        stride_q     <= vect_stride_i;
                        one_stride_q <= one_stride_i;
                        idx_q        <= '0;
                        busy_q       <= 1'b1;
                        if (nb_iter_i == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Payload registers are untouched here, so they stay stable under backpressure.
                    if (req_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done_i) begin
                        if (idx_q == last_idx) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + CNT_ONE;
                            addr_q  <= addr_q + stride_q;
                            valid_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid_o  = valid_q;
    assign req_addr_o   = addr_q;
    assign req_len_o    = len_q;
    assign req_stride_o = one_stride_q;
    assign iter_idx_o   = idx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_mac_iter_sequencer.sv
// Bench for mac_iter_sequencer.
// It runs a table of directed jobs, a few hand-written abort sequences, and random jobs.
// Expected request addresses come from base + i*stride rather than from step-by-step accumulation.

module tb_mac_iter_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [15:0] nb_iter_i;
    logic [15:0] len_iter_i;
    logic [31:0] base_addr_i;
    logic [31:0] vect_stride_i;
    logic [31:0] one_stride_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic [15:0] req_len_o;
    logic [31:0] req_stride_o;
    logic        eng_done_i;
    logic [15:0] iter_idx_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_pass   = 0;

    mac_iter_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .nb_iter_i    (nb_iter_i),
        .len_iter_i   (len_iter_i),
        .base_addr_i  (base_addr_i),
        .vect_stride_i(vect_stride_i),
        .one_stride_i (one_stride_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_addr_o   (req_addr_o),
        .req_len_o    (req_len_o),
        .req_stride_o (req_stride_o),
        .eng_done_i   (eng_done_i),
        .iter_idx_o   (iter_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] nb;
        logic [15:0] len;
        logic [31:0] base;
        logic [31:0] vs;
        logic [31:0] os;
        int          stall;
        int          delay;
        bit          noise;
        int          exp_nreq;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic scramble_params();
        nb_iter_i     = 16'($urandom_range(1, 9));
        len_iter_i    = 16'($urandom);
        base_addr_i   = $urandom;
        vect_stride_i = $urandom;
        one_stride_i  = $urandom;
    endtask

    // Drives one complete job and checks every request, the done pulse, and busy behaviour.
    // stall/delay < 0 selects random per-iteration values.
    // With noise set, start_i and eng_done_i are pulsed wherever the sequencer must ignore them.
    task automatic run_job(input logic [15:0] nb, input logic [15:0] len, input logic [31:0] base,
                           input logic [31:0] vs, input logic [31:0] os, input int stall,
                           input int delay, input bit noise, output int nreq,
                           output logic [31:0] last_addr);
        logic [31:0] exp_addr;
        int k;
        int d;
        nreq      = 0;
        last_addr = 32'h0;
        nb_iter_i     = nb;
        len_iter_i    = len;
        base_addr_i   = base;
        vect_stride_i = vs;
        one_stride_i  = os;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        scramble_params();
        if (nb == 16'd0) begin
            chk("empty_done", 64'(done_o), 64'd1);
            chk("empty_busy", 64'(busy_o), 64'd1);
            chk("empty_valid", 64'(req_valid_o), 64'd0);
            if (noise) start_i = 1'b1;
            step();
            start_i = 1'b0;
            chk("empty_done_end", 64'(done_o), 64'd0);
            chk("empty_busy_end", 64'(busy_o), 64'd0);
            chk("empty_valid_end", 64'(req_valid_o), 64'd0);
            return;
        end
        for (int i = 0; i < int'(nb); i++) begin
            exp_addr = base + vs * 32'(i);
            chk("req_valid", 64'(req_valid_o), 64'd1);
            chk("req_addr", 64'(req_addr_o), 64'(exp_addr));
            chk("req_len", 64'(req_len_o), 64'(len));
            chk("req_stride", 64'(req_stride_o), 64'(os));
            chk("iter_idx", 64'(iter_idx_o), 64'(i));
            chk("busy_issue", 64'(busy_o), 64'd1);
            chk("done_issue", 64'(done_o), 64'd0);
            k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s < k; s++) begin
                req_ready_i = 1'b0;
                if (noise) begin
                    eng_done_i = 1'b1;
                    start_i    = 1'b1;
                end
                step();
                eng_done_i = 1'b0;
                start_i    = 1'b0;
                chk("stall_valid", 64'(req_valid_o), 64'd1);
                chk("stall_addr", 64'(req_addr_o), 64'(exp_addr));
                chk("stall_len", 64'(req_len_o), 64'(len));
                chk("stall_stride", 64'(req_stride_o), 64'(os));
            end
            req_ready_i = 1'b1;
            if (noise) eng_done_i = 1'b1;
            step();
            req_ready_i = 1'b0;
            eng_done_i  = 1'b0;
            nreq++;
            last_addr = exp_addr;
            chk("wait_valid", 64'(req_valid_o), 64'd0);
            chk("wait_done", 64'(done_o), 64'd0);
            d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
            for (int s = 0; s < d; s++) begin
                if (noise) start_i = 1'b1;
                step();
                start_i = 1'b0;
                chk("wait_idle_valid", 64'(req_valid_o), 64'd0);
                chk("wait_idle_done", 64'(done_o), 64'd0);
                chk("wait_busy", 64'(busy_o), 64'd1);
            end
            eng_done_i = 1'b1;
            step();
            eng_done_i = 1'b0;
        end
        chk("fin_done", 64'(done_o), 64'd1);
        chk("fin_busy", 64'(busy_o), 64'd1);
        chk("fin_valid", 64'(req_valid_o), 64'd0);
        chk("fin_idx", 64'(iter_idx_o), 64'(nb - 16'd1));
        if (noise) start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("idle_done", 64'(done_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_idx", 64'(iter_idx_o), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_valid"}, 64'(req_valid_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_idx"}, 64'(iter_idx_o), 64'd0);
        chk({tag, "_addr"}, 64'(req_addr_o), 64'd0);
        chk({tag, "_len"}, 64'(req_len_o), 64'd0);
        chk({tag, "_stride"}, 64'(req_stride_o), 64'd0);
    endtask

    initial begin
        int          nreq;
        logic [31:0] last;
        logic [15:0] rnb;

        vecs[0] = '{16'd3, 16'd8,  32'h0000_1000, 32'h0000_0040, 32'd4, 0, 0, 1'b0, 3, 32'h0000_1080};
        vecs[1] = '{16'd0, 16'd5,  32'h0000_2000, 32'h0000_0010, 32'd4, 0, 0, 1'b0, 0, 32'h0000_0000};
        vecs[2] = '{16'd2, 16'd16, 32'hFFFF_FFC0, 32'h0000_0040, 32'd8, 0, 1, 1'b0, 2, 32'h0000_0000};
        vecs[3] = '{16'd1, 16'd3,  32'hABCD_0000, 32'h0000_0100, 32'd2, 5, 2, 1'b0, 1, 32'hABCD_0000};
        vecs[4] = '{16'd4, 16'd1,  32'h0000_0000, 32'hFFFF_FFFF, 32'd1, 1, 3, 1'b1, 4, 32'hFFFF_FFFD};
        vecs[5] = '{16'd2, 16'd7,  32'h0000_3000, 32'h0000_0020, 32'd4, 2, 0, 1'b1, 2, 32'h0000_3020};
        vecs[6] = '{16'd0, 16'd2,  32'h0000_4000, 32'h0000_0020, 32'd4, 0, 0, 1'b1, 0, 32'h0000_0000};

        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        start_i       = 1'b0;
        req_ready_i   = 1'b0;
        eng_done_i    = 1'b0;
        nb_iter_i     = 16'd0;
        len_iter_i    = 16'd0;
        base_addr_i   = 32'd0;
        vect_stride_i = 32'd0;
        one_stride_i  = 32'd0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        step();
        chk("post_reset_busy", 64'(busy_o), 64'd0);

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].nb, vecs[v].len, vecs[v].base, vecs[v].vs, vecs[v].os,
                    vecs[v].stall, vecs[v].delay, vecs[v].noise, nreq, last);
            chk($sformatf("vec%0d_nreq", v), 64'(nreq), 64'(vecs[v].exp_nreq));
            if (vecs[v].exp_nreq > 0)
                chk($sformatf("vec%0d_last_addr", v), 64'(last), 64'(vecs[v].exp_last));
            step();
        end

        // Clear during WAIT of iteration 1 of 4, with a simultaneous eng_done_i.
        nb_iter_i = 16'd4; len_iter_i = 16'd9; base_addr_i = 32'h5000;
        vect_stride_i = 32'h80; one_stride_i = 32'd4;
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("clr_valid0", 64'(req_valid_o), 64'd1);
        req_ready_i = 1'b1; step(); req_ready_i = 1'b0;
        eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
        chk("clr_valid1", 64'(req_valid_o), 64'd1);
        chk("clr_addr1", 64'(req_addr_o), 64'h5080);
        chk("clr_idx1", 64'(iter_idx_o), 64'd1);
        req_ready_i = 1'b1; step(); req_ready_i = 1'b0;
        chk("clr_wait", 64'(req_valid_o), 64'd0);
        clear_i = 1'b1; eng_done_i = 1'b1; step(); clear_i = 1'b0; eng_done_i = 1'b0;
        chk_all_zero("clear");
        for (int s = 0; s < 4; s++) begin
            eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
            chk("clr_no_done", 64'(done_o), 64'd0);
            chk("clr_no_valid", 64'(req_valid_o), 64'd0);
        end
        run_job(16'd4, 16'd9, 32'h5000, 32'h80, 32'd4, 0, 0, 1'b0, nreq, last);
        chk("clr_rerun_nreq", 64'(nreq), 64'd4);
        chk("clr_rerun_last", 64'(last), 64'h5180);
        step();

        // Asynchronous reset while a request is pending.
        nb_iter_i = 16'd3; base_addr_i = 32'h7000; vect_stride_i = 32'h10;
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("rst_pending_valid", 64'(req_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        rst_ni = 1'b1;
        step();
        chk("rst_no_done", 64'(done_o), 64'd0);
        chk("rst_idle", 64'(busy_o), 64'd0);

        // Random jobs checked against base + i*stride.
        for (int j = 0; j < 25; j++) begin
            rnb = 16'($urandom_range(0, 6));
            run_job(rnb, 16'($urandom), $urandom, $urandom, $urandom, -1, -1,
                    1'($urandom_range(0, 1)), nreq, last);
            chk("rand_nreq", 64'(nreq), 64'(rnb));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
